cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the four execution units: int, mult, div and mem.
- Each unit hands over finished results through a valid/ready handshake into a private result FIFO.
- A round-robin arbiter pops at most one FIFO head per cycle and drives it onto a registered CDB.
- Sits between the execution units and the CDB consumers (reservation stations, ROB, register status table). It replaces the fixed-priority CDB select in the issue path.

---
 rtl/cdb_arbiter.sv | 148 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: four per-unit result FIFOs drained round-robin,
// one entry per cycle, onto a registered CDB.
module cdb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int FLAG_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_int_valid,
    input  logic              i_mult_valid,
    input  logic              i_div_valid,
    input  logic              i_mem_valid,
    input  logic [TAG_W-1:0]  i_int_tag,
    input  logic [TAG_W-1:0]  i_mult_tag,
    input  logic [TAG_W-1:0]  i_div_tag,
    input  logic [TAG_W-1:0]  i_mem_tag,
    input  logic [DATA_W-1:0] i_int_data,
    input  logic [DATA_W-1:0] i_mult_data,
    input  logic [DATA_W-1:0] i_div_data,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [FLAG_W-1:0] i_int_flags,
    input  logic [FLAG_W-1:0] i_mult_flags,
    input  logic [FLAG_W-1:0] i_div_flags,
    input  logic [FLAG_W-1:0] i_mem_flags,
    output logic              o_int_ready,
    output logic              o_mult_ready,
    output logic              o_div_ready,
    output logic              o_mem_ready,
    output logic              o_cdb_valid,
    output logic [TAG_W-1:0]  o_cdb_tag,
    output logic [DATA_W-1:0] o_cdb_data,
    output logic [FLAG_W-1:0] o_cdb_flags,
    output logic [1:0]        o_cdb_src,
    output logic [3:0]        o_pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TAG_W + DATA_W + FLAG_W;

    logic [3:0]       in_valid;
    logic [ENT_W-1:0] in_entry [4];
    logic [3:0]       ready;
    logic [3:0]       cand;
    logic [3:0]       push;
    logic [3:0]       pop;
    logic [ENT_W-1:0] head [4];

    logic             grant_valid;
    logic [1:0]       grant;
    logic [1:0]       rr_reg;
    logic [1:0]       rr_next;

    logic             cdb_valid_reg;
    logic [ENT_W-1:0] cdb_entry_reg;
    logic [1:0]       cdb_src_reg;

    assign in_valid    = {i_mem_valid, i_div_valid, i_mult_valid, i_int_valid};
    assign in_entry[0] = {i_int_tag,  i_int_data,  i_int_flags};
    assign in_entry[1] = {i_mult_tag, i_mult_data, i_mult_flags};
    assign in_entry[2] = {i_div_tag,  i_div_data,  i_div_flags};
    assign in_entry[3] = {i_mem_tag,  i_mem_data,  i_mem_flags};

    assign o_int_ready  = ready[0];
    assign o_mult_ready = ready[1];
    assign o_div_ready  = ready[2];
    assign o_mem_ready  = ready[3];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
            logic [ENT_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0] count_reg;

            // Ready comes from the start-of-cycle count, so a pop never frees a slot early.
            assign ready[gi]  = (count_reg < CNT_W'(DEPTH));
            assign cand[gi]   = (count_reg != '0);
            assign push[gi]   = in_valid[gi] & ready[gi] & ~i_flush & ~i_rst;
            assign pop[gi]    = grant_valid & (grant == 2'(gi)) & ~i_flush;
            assign head[gi]   = mem[rd_ptr_reg];
            assign o_pending[gi] = cand[gi];

            always_ff @(posedge i_clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= in_entry[gi];
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst || i_flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    count_reg <= count_reg + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
                end
            end
        end
    endgenerate

    // Descending scan so the candidate closest to rr_reg is the one left standing.
    always_comb begin
        grant_valid = 1'b0;
        grant       = rr_reg;
        for (int i = 3; i >= 0; i--) begin
            if (cand[rr_reg + 2'(i)]) begin
                grant_valid = 1'b1;
                grant       = rr_reg + 2'(i);
            end
        end
        rr_next = grant_valid ? (grant + 2'd1) : rr_reg;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_reg        <= 2'd0;
            cdb_valid_reg <= 1'b0;
            cdb_entry_reg <= '0;
            cdb_src_reg   <= 2'd0;
        end else if (i_flush) begin
            cdb_valid_reg <= 1'b0;
        end else begin
            rr_reg        <= rr_next;
            cdb_valid_reg <= grant_valid;
            if (grant_valid) begin
                cdb_entry_reg <= head[grant];
                cdb_src_reg   <= grant;
            end
        end
    end

    assign o_cdb_valid = cdb_valid_reg;
    assign o_cdb_tag   = cdb_entry_reg[ENT_W-1 -: TAG_W];
    assign o_cdb_data  = cdb_entry_reg[FLAG_W +: DATA_W];
    assign o_cdb_flags = cdb_entry_reg[FLAG_W-1:0];
    assign o_cdb_src   = cdb_src_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, ordering, round-robin fairness,
// backpressure, flush and mid-stream reset.
module tb_cdb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_int_valid = 1'b0, i_mult_valid = 1'b0, i_div_valid = 1'b0, i_mem_valid = 1'b0;
    logic [5:0]  i_int_tag = '0, i_mult_tag = '0, i_div_tag = '0, i_mem_tag = '0;
    logic [31:0] i_int_data = '0, i_mult_data = '0, i_div_data = '0, i_mem_data = '0;
    logic [2:0]  i_int_flags = '0, i_mult_flags = '0, i_div_flags = '0, i_mem_flags = '0;
    logic        o_int_ready, o_mult_ready, o_div_ready, o_mem_ready;
    logic        o_cdb_valid;
    logic [5:0]  o_cdb_tag;
    logic [31:0] o_cdb_data;
    logic [2:0]  o_cdb_flags;
    logic [1:0]  o_cdb_src;
    logic [3:0]  o_pending;

    logic [3:0]  rdy_vec;
    logic [40:0] cdb_word;
    assign rdy_vec  = {o_mem_ready, o_div_ready, o_mult_ready, o_int_ready};
    assign cdb_word = {o_cdb_tag, o_cdb_data, o_cdb_flags};

    int n_checks = 0;
    int n_fail   = 0;

    localparam int BP_V[9]    = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    localparam int BP_SRC[9]  = '{0, 1, 2, 3, 1, 2, 3, 2, 0};
    localparam int BP_IDX[9]  = '{0, 0, 0, 0, 1, 1, 1, 2, 0};
    localparam int BP_DRDY[4] = '{1, 0, 1, 0};

    cdb_arbiter #(.DEPTH(2), .TAG_W(6), .DATA_W(32), .FLAG_W(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_int_valid(i_int_valid), .i_mult_valid(i_mult_valid),
        .i_div_valid(i_div_valid), .i_mem_valid(i_mem_valid),
        .i_int_tag(i_int_tag), .i_mult_tag(i_mult_tag),
        .i_div_tag(i_div_tag), .i_mem_tag(i_mem_tag),
        .i_int_data(i_int_data), .i_mult_data(i_mult_data),
        .i_div_data(i_div_data), .i_mem_data(i_mem_data),
        .i_int_flags(i_int_flags), .i_mult_flags(i_mult_flags),
        .i_div_flags(i_div_flags), .i_mem_flags(i_mem_flags),
        .o_int_ready(o_int_ready), .o_mult_ready(o_mult_ready),
        .o_div_ready(o_div_ready), .o_mem_ready(o_mem_ready),
        .o_cdb_valid(o_cdb_valid), .o_cdb_tag(o_cdb_tag),
        .o_cdb_data(o_cdb_data), .o_cdb_flags(o_cdb_flags),
        .o_cdb_src(o_cdb_src), .o_pending(o_pending)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [40:0] cont_word(input int k, input int s);
        return {6'(k * 16 + s), 32'(k * 1000 + s), 3'(s)};
    endfunction

    function automatic logic [40:0] bp_word(input int k, input int i);
        return {6'(k * 16 + i), 32'(k * 256 + i), 3'(k + i)};
    endfunction

    task automatic drive_src(input int k, input logic v, input logic [40:0] w);
        case (k)
            0: begin i_int_valid = v;  i_int_tag = w[40:35];  i_int_data = w[34:3];  i_int_flags = w[2:0];  end
            1: begin i_mult_valid = v; i_mult_tag = w[40:35]; i_mult_data = w[34:3]; i_mult_flags = w[2:0]; end
            2: begin i_div_valid = v;  i_div_tag = w[40:35];  i_div_data = w[34:3];  i_div_flags = w[2:0];  end
            default: begin i_mem_valid = v; i_mem_tag = w[40:35]; i_mem_data = w[34:3]; i_mem_flags = w[2:0]; end
        endcase
    endtask

    task automatic idle_all();
        for (int k = 0; k < 4; k++) drive_src(k, 1'b0, '0);
    endtask

    task automatic do_reset();
        idle_all();
        i_flush = 1'b0;
        i_rst   = 1'b1;
        tick();
        i_rst   = 1'b0;
    endtask

    task automatic test_reset();
        drive_src(0, 1'b1, bp_word(0, 1));
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        idle_all();
        n_checks++;
        if (o_cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_cdb_valid); end
        n_checks++;
        if (cdb_word !== 41'd0) begin n_fail++; $display("FAIL reset_payload: got %h expected 0", cdb_word); end
        n_checks++;
        if (o_cdb_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d expected 0", o_cdb_src); end
        n_checks++;
        if (o_pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b expected 0000", o_pending); end
        n_checks++;
        if (rdy_vec !== 4'b1111) begin n_fail++; $display("FAIL reset_ready: got %b expected 1111", rdy_vec); end
        tick();
        n_checks++;
        if (o_cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got valid %b expected 0", o_cdb_valid); end
    endtask

    task automatic test_staggered();
        logic [40:0] exp_w;
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            idle_all();
            if (k < 4) drive_src(k, 1'b1, {6'h0A + 6'(k), 32'(k + 1), 3'(7 - k)});
            tick();
            n_checks++;
            if (k >= 1 && k <= 4) begin
                exp_w = {6'h0A + 6'(k - 1), 32'(k), 3'(8 - k)};
                if (o_cdb_valid !== 1'b1 || o_cdb_src !== 2'(k - 1) || cdb_word !== exp_w) begin
                    n_fail++;
                    $display("FAIL stagger_%0d: got v=%b src=%0d word=%h expected v=1 src=%0d word=%h",
                             k, o_cdb_valid, o_cdb_src, cdb_word, k - 1, exp_w);
                end
            end else if (o_cdb_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stagger_%0d: got valid %b expected 0", k, o_cdb_valid);
            end
            if (k == 0) begin
                n_checks++;
                if (o_pending !== 4'b0001) begin n_fail++; $display("FAIL stagger_pending: got %b expected 0001", o_pending); end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0]  exp_p;
        logic [40:0] exp_w;
        do_reset();
        for (int k = 0; k < 4; k++) drive_src(k, 1'b1, {6'h0A + 6'(k), 32'h10 + 32'(k), 3'(k)});
        tick();
        idle_all();
        n_checks++;
        if (o_pending !== 4'b1111 || o_cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_push: got pending=%b valid=%b expected 1111/0", o_pending, o_cdb_valid);
        end
        for (int j = 0; j < 5; j++) begin
            tick();
            exp_p = 4'b1111 << (j + 1);
            n_checks++;
            if (o_pending !== exp_p) begin n_fail++; $display("FAIL simul_pending_%0d: got %b expected %b", j, o_pending, exp_p); end
            n_checks++;
            if (j < 4) begin
                exp_w = {6'h0A + 6'(j), 32'h10 + 32'(j), 3'(j)};
                if (o_cdb_valid !== 1'b1 || o_cdb_src !== 2'(j) || cdb_word !== exp_w) begin
                    n_fail++;
                    $display("FAIL simul_grant_%0d: got v=%b src=%0d word=%h expected v=1 src=%0d word=%h",
                             j, o_cdb_valid, o_cdb_src, cdb_word, j, exp_w);
                end
            end else if (o_cdb_valid !== 1'b0 || o_cdb_src !== 2'd3 || o_cdb_tag !== 6'h0D) begin
                n_fail++;
                $display("FAIL simul_idle: got v=%b src=%0d tag=%h expected v=0 src=3 tag=0d",
                         o_cdb_valid, o_cdb_src, o_cdb_tag);
            end
        end
    endtask

    task automatic test_continuous();
        logic [40:0] sb [4][$];
        int          cnt [4];
        int          seq [4];
        logic        acc [4];
        logic [1:0]  es;
        logic        done;
        do_reset();
        for (int k = 0; k < 4; k++) begin cnt[k] = 0; seq[k] = 0; end
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 4; k++) begin
                acc[k] = (cnt[k] < 2);
                n_checks++;
                if (rdy_vec[k] !== acc[k]) begin
                    n_fail++;
                    $display("FAIL cont_ready_%0d_%0d: got %b expected %b", j, k, rdy_vec[k], acc[k]);
                end
                drive_src(k, 1'b1, cont_word(k, seq[k]));
            end
            tick();
            n_checks++;
            if (j == 0) begin
                if (o_cdb_valid !== 1'b0) begin n_fail++; $display("FAIL cont_first: got valid %b expected 0", o_cdb_valid); end
            end else begin
                es = 2'((j - 1) % 4);
                if (o_cdb_valid !== 1'b1 || o_cdb_src !== es || sb[es].size() == 0 || cdb_word !== sb[es][0]) begin
                    n_fail++;
                    $display("FAIL cont_grant_%0d: got v=%b src=%0d word=%h expected v=1 src=%0d word=%h",
                             j, o_cdb_valid, o_cdb_src, cdb_word, es, (sb[es].size() > 0) ? sb[es][0] : 41'd0);
                end
                if (sb[es].size() > 0) void'(sb[es].pop_front());
                cnt[es]--;
            end
            for (int k = 0; k < 4; k++) begin
                if (acc[k]) begin
                    sb[k].push_back(cont_word(k, seq[k]));
                    seq[k]++;
                    cnt[k]++;
                end
            end
        end
        idle_all();
        for (int d = 0; d < 20; d++) begin
            tick();
            if (o_cdb_valid === 1'b1) begin
                es = o_cdb_src;
                n_checks++;
                if (sb[es].size() == 0 || cdb_word !== sb[es][0]) begin
                    n_fail++;
                    $display("FAIL cont_drain_%0d: got src=%0d word=%h expected word=%h",
                             d, es, cdb_word, (sb[es].size() > 0) ? sb[es][0] : 41'd0);
                end
                if (sb[es].size() > 0) void'(sb[es].pop_front());
            end else begin
                break;
            end
        end
        done = (sb[0].size() == 0) && (sb[1].size() == 0) && (sb[2].size() == 0) && (sb[3].size() == 0);
        n_checks++;
        if (!done || o_pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL cont_lost: got left=%0d/%0d/%0d/%0d pending=%b expected none left, 0000",
                     sb[0].size(), sb[1].size(), sb[2].size(), sb[3].size(), o_pending);
        end
    endtask

    task automatic test_backpressure();
        logic [40:0] exp_w;
        do_reset();
        for (int s = 0; s < 9; s++) begin
            idle_all();
            if (s < 2) begin
                drive_src(1, 1'b1, bp_word(1, s));
                drive_src(2, 1'b1, bp_word(2, s));
                drive_src(3, 1'b1, bp_word(3, s));
            end else if (s < 4) begin
                drive_src(2, 1'b1, bp_word(2, 2));
            end
            tick();
            if (s < 4) begin
                n_checks++;
                if (o_div_ready !== 1'(BP_DRDY[s])) begin
                    n_fail++;
                    $display("FAIL bp_div_ready_%0d: got %b expected %0d", s, o_div_ready, BP_DRDY[s]);
                end
            end
            n_checks++;
            exp_w = bp_word(BP_SRC[s], BP_IDX[s]);
            if (o_cdb_valid !== 1'(BP_V[s]) ||
                (BP_V[s] == 1 && (o_cdb_src !== 2'(BP_SRC[s]) || cdb_word !== exp_w))) begin
                n_fail++;
                $display("FAIL bp_cdb_%0d: got v=%b src=%0d word=%h expected v=%0d src=%0d word=%h",
                         s, o_cdb_valid, o_cdb_src, cdb_word, BP_V[s], BP_SRC[s], exp_w);
            end
        end
    endtask

    task automatic test_flush();
        logic [1:0] es;
        do_reset();
        for (int k = 0; k < 4; k++) drive_src(k, 1'b1, bp_word(k, 0));
        tick();
        idle_all();
        drive_src(1, 1'b1, bp_word(1, 1));
        drive_src(2, 1'b1, bp_word(2, 1));
        tick();
        n_checks++;
        if (o_pending !== 4'b1110 || o_cdb_src !== 2'd0 || o_cdb_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup: got pending=%b src=%0d v=%b expected 1110/0/1", o_pending, o_cdb_src, o_cdb_valid);
        end
        idle_all();
        drive_src(0, 1'b1, bp_word(0, 5));
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        idle_all();
        n_checks++;
        if (o_cdb_valid !== 1'b0 || o_pending !== 4'b0000 || rdy_vec !== 4'b1111) begin
            n_fail++;
            $display("FAIL flush_clear: got v=%b pending=%b ready=%b expected 0/0000/1111", o_cdb_valid, o_pending, rdy_vec);
        end
        tick();
        n_checks++;
        if (o_cdb_valid !== 1'b0 || o_pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_drop: got v=%b pending=%b expected 0/0000", o_cdb_valid, o_pending);
        end
        for (int k = 0; k < 4; k++) drive_src(k, 1'b1, bp_word(k, 7));
        tick();
        idle_all();
        for (int j = 0; j < 4; j++) begin
            tick();
            es = 2'((j + 1) % 4);
            n_checks++;
            if (o_cdb_valid !== 1'b1 || o_cdb_src !== es || cdb_word !== bp_word(es, 7)) begin
                n_fail++;
                $display("FAIL flush_rr_%0d: got v=%b src=%0d word=%h expected v=1 src=%0d word=%h",
                         j, o_cdb_valid, o_cdb_src, cdb_word, es, bp_word(es, 7));
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int k = 0; k < 4; k++) drive_src(k, 1'b1, bp_word(k, 3));
        tick();
        idle_all();
        tick();
        tick();
        n_checks++;
        if (o_cdb_valid !== 1'b1 || o_cdb_src !== 2'd1) begin
            n_fail++;
            $display("FAIL rstmid_stream: got v=%b src=%0d expected 1/1", o_cdb_valid, o_cdb_src);
        end
        drive_src(0, 1'b1, bp_word(0, 9));
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        idle_all();
        n_checks++;
        if (o_cdb_valid !== 1'b0 || cdb_word !== 41'd0 || o_cdb_src !== 2'd0 || o_pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_clear: got v=%b word=%h src=%0d pending=%b expected all 0",
                     o_cdb_valid, cdb_word, o_cdb_src, o_pending);
        end
        tick();
        n_checks++;
        if (o_cdb_valid !== 1'b0 || o_pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_drop: got v=%b pending=%b expected 0/0000", o_cdb_valid, o_pending);
        end
        for (int k = 0; k < 4; k++) drive_src(k, 1'b1, bp_word(k, 4));
        tick();
        idle_all();
        tick();
        n_checks++;
        if (o_cdb_valid !== 1'b1 || o_cdb_src !== 2'd0 || cdb_word !== bp_word(0, 4)) begin
            n_fail++;
            $display("FAIL rstmid_first: got v=%b src=%0d word=%h expected v=1 src=0 word=%h",
                     o_cdb_valid, o_cdb_src, cdb_word, bp_word(0, 4));
        end
    endtask

    initial begin
        test_reset();
        test_staggered();
        test_simultaneous();
        test_continuous();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
